regfile_wr_arbiter: RTL and testbench
=====================================

// Module: regfile_wr_arbiter
// PURPOSE
//   Round-robin arbiter sharing the single write port of the flop-based MIPS
//   register bank among NREQ requesters (e.g. ALU writeback, load return, link).
//   Samples requests, issues a registered one-hot grant, and drives the bank's
//   wr_en/wr_addr/wr_data from the granted requester. Sits between the pipeline
//   writeback stages and the register bank.
// PARAMETERS
//   NREQ  4   number of requesters (2..8)
//   AW    5   register address width
//   DW    32  register data width
// PORTS
//   clock     in   1        rising-edge clock
//   reset     in   1        synchronous, active-low reset
//   req       in   NREQ     per-requester write request, held until granted
//   req_addr  in   NREQ*AW  requester i address at [i*AW +: AW]
//   req_data  in   NREQ*DW  requester i data at [i*DW +: DW]
//   hold      in   1        pipeline stall; blocks new grants
//   gnt       out  NREQ     one-hot grant pulse, registered
//   wr_en     out  1        register bank write enable, registered
//   wr_addr   out  AW       register bank write address, registered
//   wr_data   out  DW       register bank write data, registered
//   busy      out  1        combinational: any eligible request pending
// BEHAVIOUR
//   - Reset (reset==0 at rising clock): gnt=0, wr_en=0, wr_addr=0, wr_data=0,
//     rr pointer=0, mask=0. Reset overrides all other inputs.
//   - Eligible set E = req & ~mask. mask = gnt of the current cycle, so the
//     requester granted in cycle k is ineligible at the edge ending cycle k.
//     This prevents a double grant while the requester drops req.
//   - At each edge with hold==0 and E!=0: pick the first set bit of E, searching
//     from index ptr upward with wrap NREQ-1 -> 0. Set gnt to one-hot(winner).
//     Set ptr to (winner+1) mod NREQ. Register wr_addr/wr_data from the winner's slice.
//   - wr_en = 1 with the grant unless the winner's address is 0. A write to
//     $zero is granted (gnt pulses, so the requester retires) but wr_en=0.
//   - Latency: req high before edge k yields gnt/wr_en high for exactly cycle
//     k..k+1 (one clock). Requesters must deassert req before the next edge after
//     seeing gnt; otherwise the request becomes eligible again one cycle later.
//   - If E==0 or hold==1: gnt=0, wr_en=0. wr_addr/wr_data hold their last
//     values. ptr is unchanged. mask is cleared, so a hold cycle re-enables
//     the last winner.
//   - gnt is always zero or one-hot. At most one write per cycle.
//   - busy = |E && !hold (combinational).
//   - req_addr/req_data of non-winning requesters are ignored.
//   - Single requester continuously requesting: grant pattern is 1,0,1,0,...
//     because of the mask bubble.
// TESTING
//   1. Reset: hold reset=0 for 2 edges with req=4'b1111 -> gnt=0, wr_en=0,
//      wr_addr=0, wr_data=0. Release reset -> first grant goes to req 0.
//   2. Round-robin: req=4'b1111 held, each requester drops after its grant.
//      Expect gnt 0001,0010,0100,1000 on consecutive cycles. wr_addr/wr_data
//      match each requester's slice.
//   3. Wrap and mask: ptr=3, req=4'b1001 with req 3 held after grant.
//      Expect gnt 1000 -> 0001 -> 1000.
//   4. Zero register: requester 2 requests addr 0, data 32'hDEAD_BEEF.
//      Expect gnt=0100 for one cycle with wr_en=0.
//   5. Hold: hold=1 for 3 cycles with req=4'b0110. Expect gnt=0, wr_en=0 and
//      ptr unchanged. Drop hold -> gnt=0010 next edge.
//   6. Reset mid-operation: assert reset=0 in the cycle gnt=0100 is high.
//      Next edge all outputs are 0 and ptr=0.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Round-robin write-port arbiter for the flop-based register bank.
// Picks one requester per clock, starting the search at a rotating pointer,
// and registers a one-hot grant together with the bank write controls.
// The previous cycle's grant masks its owner, so a requester that is still
// dropping req cannot win twice in a row.
//
// Handshake: a requester holds req (with stable addr/data) until it sees its
// gnt bit high; it must drop req before the next rising edge. gnt is a single
// cycle pulse, and wr_en/wr_addr/wr_data are valid in that same cycle.
module regfile_wr_arbiter #(
   parameter int NREQ = 4,
   parameter int AW   = 5,
   parameter int DW   = 32
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_data,
   input  logic               hold,
   output logic [NREQ-1:0]    gnt,
   output logic               wr_en,
   output logic [AW-1:0]      wr_addr,
   output logic [DW-1:0]      wr_data,
   output logic               busy
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0] gnt_q, gnt_d;
   logic            wr_en_q, wr_en_d;
   logic [AW-1:0]   wr_addr_q, wr_addr_d;
   logic [DW-1:0]   wr_data_q, wr_data_d;
   logic [PW-1:0]   ptr_q, ptr_d;

   logic [NREQ-1:0] elig;
   logic            win_found;
   logic [PW-1:0]   win_idx;
   logic [AW-1:0]   win_addr;
   logic [DW-1:0]   win_data;

   // Index of the requester 'off' places after the pointer, with wrap.
   function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] ptr, input int off);
      return PW'((int'(ptr) + off) % NREQ);
   endfunction

   // Eligibility, busy flag and the rotating first-set-bit search.
   // The mask is simply the grant currently on the outputs: a hold or idle
   // cycle drives gnt to zero, which also clears the mask.
   always_comb begin
      elig      = req & ~gnt_q;
      busy      = (|elig) && !hold;
      win_found = 1'b0;
      win_idx   = '0;
      for (int off = 0; off < NREQ; off++) begin
         if (!win_found && elig[rr_idx(ptr_q, off)]) begin
            win_found = 1'b1;
            win_idx   = rr_idx(ptr_q, off);
         end
      end
      win_addr = req_addr[win_idx*AW +: AW];
      win_data = req_data[win_idx*DW +: DW];
   end

   // Next-state: grant the winner unless stalled or nothing is eligible.
   // A write to register 0 still grants (so the requester retires) but
   // leaves wr_en low.
   always_comb begin
      gnt_d     = '0;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      ptr_d     = ptr_q;
      if (!hold && win_found) begin
         gnt_d     = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
         wr_en_d   = |win_addr;
         wr_addr_d = win_addr;
         wr_data_d = win_data;
         ptr_d     = (int'(win_idx) == NREQ-1) ? '0 : win_idx + 1'b1;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         gnt_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         ptr_q     <= '0;
      end else begin
         gnt_q     <= gnt_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         ptr_q     <= ptr_d;
      end
   end

   assign gnt     = gnt_q;
   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter (NREQ=4, AW=5, DW=32).
module tb_regfile_wr_arbiter;

   localparam int NREQ = 4;
   localparam int AW   = 5;
   localparam int DW   = 32;

   logic               clock;
   logic               reset;
   logic [NREQ-1:0]    req;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_data;
   logic               hold;
   logic [NREQ-1:0]    gnt;
   logic               wr_en;
   logic [AW-1:0]      wr_addr;
   logic [DW-1:0]      wr_data;
   logic               busy;

   int total_cnt  = 0;
   int passed_cnt = 0;

   regfile_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
      .clock    (clock),
      .reset    (reset),
      .req      (req),
      .req_addr (req_addr),
      .req_data (req_data),
      .hold     (hold),
      .gnt      (gnt),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .busy     (busy)
   );

   // Clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one edge; outputs are sampled 1 time unit after it.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_slot(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_addr[i*AW +: AW] = a;
      req_data[i*DW +: DW] = d;
   endtask

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total_cnt++;
      assert (obs === exp) passed_cnt++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic chk_out(input string tag, input logic [NREQ-1:0] e_gnt, input logic e_en,
                          input logic [AW-1:0] e_addr, input logic [DW-1:0] e_data);
      chk({tag, ".gnt"},     DW'(gnt),     DW'(e_gnt));
      chk({tag, ".wr_en"},   DW'(wr_en),   DW'(e_en));
      chk({tag, ".wr_addr"}, DW'(wr_addr), DW'(e_addr));
      chk({tag, ".wr_data"}, wr_data,      e_data);
   endtask

   initial begin
      reset    = 1'b0;
      hold     = 1'b0;
      req      = 4'b1111;
      req_addr = '0;
      req_data = '0;
      // Requester i writes register i+4 with data A000_000i.
      for (int i = 0; i < NREQ; i++) set_slot(i, AW'(i + 4), 32'hA000_0000 + DW'(i));

      // 1. Reset dominates pending requests.
      step();
      step();
      chk_out("reset", 4'b0000, 1'b0, 5'd0, 32'h0);
      reset = 1'b1;

      // 2. Round robin, each requester drops after its grant.
      step(); chk_out("rr0", 4'b0001, 1'b1, 5'd4, 32'hA000_0000); req = 4'b1110;
      step(); chk_out("rr1", 4'b0010, 1'b1, 5'd5, 32'hA000_0001); req = 4'b1100;
      step(); chk_out("rr2", 4'b0100, 1'b1, 5'd6, 32'hA000_0002); req = 4'b1000;
      step(); chk_out("rr3", 4'b1000, 1'b1, 5'd7, 32'hA000_0003); req = 4'b0000;
      step(); chk_out("idle", 4'b0000, 1'b0, 5'd7, 32'hA000_0003);
      chk("idle.busy", DW'(busy), 32'd0);

      // 3. Move ptr to 3, then wrap with req 3 held after its grant.
      req = 4'b0100;
      step(); chk("p3.gnt", DW'(gnt), 32'b0100); req = 4'b1001;
      step(); chk("wrap.a", DW'(gnt), 32'b1000);
      step(); chk("wrap.b", DW'(gnt), 32'b0001); req = 4'b1000;
      step(); chk("wrap.c", DW'(gnt), 32'b1000);
      // Single continuous requester: mask bubble then grant again.
      step(); chk("bubble", DW'(gnt), 32'b0000);
      step(); chk_out("regrant", 4'b1000, 1'b1, 5'd7, 32'hA000_0003); req = 4'b0000;
      step(); chk("idle2.gnt", DW'(gnt), 32'b0000);

      // 4. Write to $zero: granted but no bank write. ptr is 0 here.
      set_slot(2, 5'd0, 32'hDEAD_BEEF);
      req = 4'b0100;
      step(); chk_out("zero", 4'b0100, 1'b0, 5'd0, 32'hDEAD_BEEF);
      req = 4'b0000;
      set_slot(2, 5'd6, 32'hA000_0002);
      step(); chk_out("zero.after", 4'b0000, 1'b0, 5'd0, 32'hDEAD_BEEF);

      // 5. Hold for 3 cycles with two requests pending; ptr stays 3.
      hold = 1'b1;
      req  = 4'b0110;
      #1 chk("hold.busy", DW'(busy), 32'd0);
      for (int c = 0; c < 3; c++) begin
         step();
         chk("hold.gnt", DW'(gnt), 32'b0000);
         chk("hold.wr_en", DW'(wr_en), 32'd0);
      end
      hold = 1'b0;
      #1 chk("unhold.busy", DW'(busy), 32'd1);
      // From ptr 3 the search order is 3,0,1: requester 1 wins.
      step(); chk_out("unhold", 4'b0010, 1'b1, 5'd5, 32'hA000_0001); req = 4'b0100;
      step(); chk_out("pre_rst", 4'b0100, 1'b1, 5'd6, 32'hA000_0002);

      // 6. Reset in the cycle gnt=0100 is high.
      reset = 1'b0;
      req   = 4'b1111;
      step(); chk_out("midrst", 4'b0000, 1'b0, 5'd0, 32'h0);
      reset = 1'b1;
      // ptr back to 0: requester 0 wins (a stale ptr of 3 would pick 3).
      step(); chk_out("post_rst", 4'b0001, 1'b1, 5'd4, 32'hA000_0000);

      $display("%0d/%0d checks passed", passed_cnt, total_cnt);
      $finish;
   end

endmodule
